// File: rtl/jk_drv_pkg.sv
// jk_drv_pkg: shared types, fill-policy codes and sizing helpers for the JK bank driver
package jk_drv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    CHECK,
    RESP
  } state_t;

  localparam int DC_SETRESET = 0;
  localparam int DC_TOGGLE   = 1;

  function automatic int tries_width(input int max_retry);
    return $clog2(max_retry + 1);
  endfunction

  function automatic bit fill_is_toggle(input int dc_fill);
    return dc_fill == DC_TOGGLE;
  endfunction

  function automatic bit fill_is_valid(input int dc_fill);
    return dc_fill == DC_SETRESET || dc_fill == DC_TOGGLE;
  endfunction

endpackage

// File: rtl/jk_bank_driver_excite.sv
// jk_excite: per-bit J/K excitation that moves a JK bank from q to t in one edge
module jk_excite
  import jk_drv_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DC_FILL = DC_SETRESET
) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k
);

  localparam bit toggle = fill_is_toggle(DC_FILL);

  logic [WIDTH-1:0] flip;

  assign flip = q ^ t;

  // Held bits get J=K=0; changing bits get set/reset or a toggle pulse
  always_comb begin
    j = toggle ? flip : ~q & t;
    k = toggle ? flip : q & ~t;
  end

endmodule

// File: rtl/jk_bank_driver.sv
// jk_bank_driver: drives a JK bank to a requested state, verifies via Q, retries, reports status
module jk_bank_driver
  import jk_drv_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_RETRY = 3,
  parameter int DC_FILL   = DC_SETRESET,
  localparam int TW       = tries_width(MAX_RETRY)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_target,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_err,
  output logic [TW-1:0]    resp_tries,
  output logic             busy
);

  state_t           state, state_n;
  logic [WIDTH-1:0] target_reg, target_n, exc_t, exc_j, exc_k, j_n, k_n;
  logic [TW-1:0]    try_cnt, try_n, tries_n;
  logic             rv_n, err_n;

  assign req_ready = state == IDLE;
  assign exc_t     = state == IDLE ? req_target : target_reg;

  jk_excite #(
    .WIDTH  (WIDTH),
    .DC_FILL(DC_FILL)
  ) u_excite (
    .q(q_fb),
    .t(exc_t),
    .j(exc_j),
    .k(exc_k)
  );

  // Next state and next values of every registered output; J/K only leave zero when entering DRIVE
  always_comb begin
    state_n  = state;
    target_n = target_reg;
    try_n    = try_cnt;
    j_n      = '0;
    k_n      = '0;
    rv_n     = resp_valid;
    err_n    = resp_err;
    tries_n  = resp_tries;
    case (state)
      IDLE: if (req_valid) begin
        state_n  = DRIVE;
        target_n = req_target;
        try_n    = TW'(1);
        j_n      = exc_j;
        k_n      = exc_k;
      end
      DRIVE: state_n = CHECK;
      CHECK: if (q_fb == target_reg) begin
        state_n = RESP;
        rv_n    = 1'b1;
        err_n   = 1'b0;
        tries_n = try_cnt;
      end else if (try_cnt < TW'(MAX_RETRY)) begin
        state_n = DRIVE;
        try_n   = try_cnt + TW'(1);
        j_n     = exc_j;
        k_n     = exc_k;
      end else begin
        state_n = RESP;
        rv_n    = 1'b1;
        err_n   = 1'b1;
        tries_n = TW'(MAX_RETRY);
      end
      RESP: if (resp_ready) begin
        state_n = IDLE;
        rv_n    = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end

  // State, command and response registers; async reset drops J/K so the bank holds at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      target_reg <= '0;
      try_cnt    <= '0;
      j_out      <= '0;
      k_out      <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_tries <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      target_reg <= target_n;
      try_cnt    <= try_n;
      j_out      <= j_n;
      k_out      <= k_n;
      resp_valid <= rv_n;
      resp_err   <= err_n;
      resp_tries <= tries_n;
      busy       <= state_n != IDLE;
    end
  end

endmodule

// File: tb/tb_jk_bank_driver.sv
// tb_jk_bank_driver: directed checks of two 4-bit drivers (set/reset and toggle fill) against JK bank models
module tb_jk_bank_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] rvld = 2'b00;
  logic [3:0] tg = 4'h0;
  logic       rsr = 1'b1;
  logic [3:0] stuck = 4'h0;
  logic [1:0] rrdy, rsv, rse, bsy;
  logic [3:0] jo [2];
  logic [3:0] ko [2];
  logic [3:0] bank [2];
  logic [1:0] rtr [2];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jk_bank_driver #(.WIDTH(4), .MAX_RETRY(3), .DC_FILL(0)) d0 (
    .clk(clk), .rst(rst), .req_valid(rvld[0]), .req_ready(rrdy[0]), .req_target(tg),
    .q_fb(bank[0]), .j_out(jo[0]), .k_out(ko[0]), .resp_valid(rsv[0]), .resp_ready(rsr),
    .resp_err(rse[0]), .resp_tries(rtr[0]), .busy(bsy[0])
  );

  jk_bank_driver #(.WIDTH(4), .MAX_RETRY(3), .DC_FILL(1)) d1 (
    .clk(clk), .rst(rst), .req_valid(rvld[1]), .req_ready(rrdy[1]), .req_target(tg),
    .q_fb(bank[1]), .j_out(jo[1]), .k_out(ko[1]), .resp_valid(rsv[1]), .resp_ready(rsr),
    .resp_err(rse[1]), .resp_tries(rtr[1]), .busy(bsy[1])
  );

  // JK bank models: Q+ = J&~Q | ~K&Q; bank 0 can have bits held stuck at 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank[0] <= '0;
      bank[1] <= '0;
    end else begin
      bank[0] <= ((~bank[0] & jo[0]) | (bank[0] & ~ko[0])) & ~stuck;
      bank[1] <= (~bank[1] & jo[1]) | (bank[1] & ~ko[1]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic one(input int u, input logic [3:0] t, input logic [3:0] ej, input logic [3:0] ek);
    rvld[u] = 1'b1;
    tg = t;
    tick();
    chk("drive_j", 32'(jo[u]), 32'(ej));
    chk("drive_k", 32'(ko[u]), 32'(ek));
    chk("drive_busy", 32'(bsy[u]), 1);
    chk("drive_rdy", 32'(rrdy[u]), 0);
    rvld[u] = 1'b0;
    tick();
    chk("check_j", 32'(jo[u]), 0);
    chk("check_k", 32'(ko[u]), 0);
    chk("check_rv", 32'(rsv[u]), 0);
    tick();
    chk("resp_rv", 32'(rsv[u]), 1);
    chk("resp_err", 32'(rse[u]), 0);
    chk("resp_tries", 32'(rtr[u]), 1);
    chk("resp_bank", 32'(bank[u]), 32'(t));
    tick();
    chk("done_rv", 32'(rsv[u]), 0);
    chk("done_rdy", 32'(rrdy[u]), 1);
    chk("done_busy", 32'(bsy[u]), 0);
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk("rst_j", 32'(jo[0]), 0);
    chk("rst_k", 32'(ko[0]), 0);
    chk("rst_rv", 32'(rsv[0]), 0);
    chk("rst_err", 32'(rse[0]), 0);
    chk("rst_tries", 32'(rtr[0]), 0);
    chk("rst_busy", 32'(bsy[0]), 0);
    chk("rst_rdy", 32'(rrdy[0]), 1);
    tick();
    chk("idle_rdy", 32'(rrdy[0]), 1);
    one(0, 4'b1010, 4'b1010, 4'b0000);
    one(0, 4'b1100, 4'b0100, 4'b0010);
    one(0, 4'b1010, 4'b0010, 4'b0100);
    one(1, 4'b1100, 4'b1100, 4'b1100);
    one(1, 4'b1010, 4'b0110, 4'b0110);
    one(0, 4'b0101, 4'b0101, 4'b1010);
    one(0, 4'b0101, 4'b0000, 4'b0000);
    one(0, 4'b0000, 4'b0000, 4'b0101);
    stuck = 4'b0001;
    rvld[0] = 1'b1;
    tg = 4'b0001;
    tick();
    rvld[0] = 1'b0;
    for (int p = 0; p < 3; p++) begin
      chk("retry_j", 32'(jo[0]), 32'b0001);
      chk("retry_k", 32'(ko[0]), 0);
      chk("retry_rv", 32'(rsv[0]), 0);
      tick();
      chk("retry_gap_j", 32'(jo[0]), 0);
      tick();
    end
    chk("retry_rv_end", 32'(rsv[0]), 1);
    chk("retry_err", 32'(rse[0]), 1);
    chk("retry_tries", 32'(rtr[0]), 3);
    chk("retry_bank", 32'(bank[0]), 0);
    tick();
    chk("retry_done_rv", 32'(rsv[0]), 0);
    stuck = 4'b0000;
    rsr = 1'b0;
    rvld[0] = 1'b1;
    tg = 4'b0011;
    tick();
    rvld[0] = 1'b0;
    tick();
    tick();
    chk("hold_rv0", 32'(rsv[0]), 1);
    rvld[0] = 1'b1;
    tg = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("hold_rv", 32'(rsv[0]), 1);
      chk("hold_err", 32'(rse[0]), 0);
      chk("hold_tries", 32'(rtr[0]), 1);
      chk("hold_rdy", 32'(rrdy[0]), 0);
      chk("hold_busy", 32'(bsy[0]), 1);
      chk("hold_j", 32'(jo[0]), 0);
    end
    rsr = 1'b1;
    tick();
    chk("hs_rv", 32'(rsv[0]), 0);
    chk("hs_rdy", 32'(rrdy[0]), 1);
    tick();
    chk("next_j", 32'(jo[0]), 32'b1100);
    chk("next_busy", 32'(bsy[0]), 1);
    rvld[0] = 1'b0;
    tick();
    tick();
    chk("next_rv", 32'(rsv[0]), 1);
    chk("next_bank", 32'(bank[0]), 32'b1111);
    tick();
    rvld[0] = 1'b1;
    tg = 4'b0000;
    tick();
    chk("pre_rst_k", 32'(ko[0]), 32'b1111);
    rvld[0] = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("async_j", 32'(jo[0]), 0);
    chk("async_k", 32'(ko[0]), 0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_rv", 32'(rsv[0]), 0);
    chk("post_rst_busy", 32'(bsy[0]), 0);
    chk("post_rst_rdy", 32'(rrdy[0]), 1);
    one(0, 4'b0110, 4'b0110, 4'b0000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
